// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I pipelined control path.
// Holds opcode constants, the ALU / immediate-select / result-select
// encodings, and the packed control bundles carried by the E, M and W
// pipeline registers. Each later stage's bundle is nested inside the
// earlier one, so a stage advance is a plain sub-field copy.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
  } w_ctrl_t;

  typedef struct packed {
    w_ctrl_t w;
    logic    mem_write;
  } m_ctrl_t;

  typedef struct packed {
    m_ctrl_t    m;
    logic       jump;
    logic       branch;
    logic       jalr;
    logic [2:0] funct3;
    alu_op_e    alu_control;
    logic       alu_src;
    logic       alu_a_pc;
  } e_ctrl_t;

  localparam int W_CTRL_W = $bits(w_ctrl_t);
  localparam int M_CTRL_W = $bits(m_ctrl_t);
  localparam int E_CTRL_W = $bits(e_ctrl_t);

  // A bubble is the all-zero bundle: no writes, no redirect, ADD.
  localparam e_ctrl_t E_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational main + ALU decoder for the Decode stage.
// Ports:
//   op, funct3, funct7 : instruction fields from the D stage
//   ctrl               : full control bundle for the E/M/W stages
//   imm_src            : immediate format select (I/S/B/J/U)
//   illegal            : unknown opcode, opcode disabled by parameter,
//                        or a bad funct7 on an R-type / shift-immediate
module ctrl_decoder
  import rv_ctrl_pkg::*;
#(
  parameter bit EN_JUMP   = 1'b1,
  parameter bit EN_UPPER  = 1'b1,
  parameter bit EN_BR_EXT = 1'b1
) (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output e_ctrl_t    ctrl,
  output logic [2:0] imm_src,
  output logic       illegal
);

  logic f7_ok;
  logic f7_alt;

  assign f7_ok  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
  assign f7_alt = funct7[5];

  // funct7[5] selects SUB only on register-register adds (on ADDI it is
  // an immediate bit), but selects SRA on both shift forms.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3,
                                          input logic       alt,
                                          input logic       is_r);
    alu_op_e r;
    case (f3)
      3'b000:  r = (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  function automatic logic branch_legal(input logic [2:0] f3);
    logic r;
    case (f3)
      3'b000:                             r = 1'b1;
      3'b001, 3'b100, 3'b101,
      3'b110, 3'b111:                     r = EN_BR_EXT;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    ctrl        = E_BUBBLE;
    ctrl.funct3 = funct3;
    imm_src     = IMM_I;
    illegal     = 1'b0;
    case (op)
      OP_R: begin
        ctrl.m.w.reg_write = 1'b1;
        ctrl.alu_control   = alu_from_f3(funct3, f7_alt, 1'b1);
        illegal            = !f7_ok;
      end
      OP_I: begin
        ctrl.m.w.reg_write = 1'b1;
        ctrl.alu_src       = 1'b1;
        ctrl.alu_control   = alu_from_f3(funct3, f7_alt, 1'b0);
        // funct7 is only an encoding field on the shift-immediates.
        if (funct3 == 3'b001 || funct3 == 3'b101) illegal = !f7_ok;
      end
      OP_LOAD: begin
        ctrl.m.w.reg_write  = 1'b1;
        ctrl.m.w.result_src = RES_MEM;
        ctrl.alu_src        = 1'b1;
      end
      OP_STORE: begin
        ctrl.m.mem_write = 1'b1;
        ctrl.alu_src     = 1'b1;
        imm_src          = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        imm_src          = IMM_B;
        illegal          = !branch_legal(funct3);
      end
      OP_JAL: begin
        ctrl.jump           = 1'b1;
        ctrl.m.w.reg_write  = 1'b1;
        ctrl.m.w.result_src = RES_PC4;
        ctrl.alu_a_pc       = 1'b1;
        ctrl.alu_src        = 1'b1;
        imm_src             = IMM_J;
        illegal             = !EN_JUMP;
      end
      OP_JALR: begin
        ctrl.jump           = 1'b1;
        ctrl.jalr           = 1'b1;
        ctrl.m.w.reg_write  = 1'b1;
        ctrl.m.w.result_src = RES_PC4;
        ctrl.alu_src        = 1'b1;
        illegal             = !EN_JUMP;
      end
      OP_LUI: begin
        ctrl.m.w.reg_write = 1'b1;
        ctrl.alu_src       = 1'b1;
        ctrl.alu_control   = ALU_PASS_B;
        imm_src            = IMM_U;
        illegal            = !EN_UPPER;
      end
      OP_AUIPC: begin
        ctrl.m.w.reg_write = 1'b1;
        ctrl.alu_src       = 1'b1;
        ctrl.alu_a_pc      = 1'b1;
        imm_src            = IMM_U;
        illegal            = !EN_UPPER;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Control path of the 5-stage RV32I core.
// Decodes in D, carries control through ID/EX, EX/MEM and MEM/WB, inserts
// bubbles on flush or illegal instructions, and resolves branches in EX.
// ALU_CTRL_W must be at least 4.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   op, funct3, funct7       : D-stage instruction fields
//   hold                     : freeze all three pipeline registers
//   flush_e                  : load ID/EX with a bubble
//   zero_e, lt_e, ltu_e      : EX-stage ALU comparison flags
//   imm_src_d, illegal_d     : D-stage combinational decode outputs
//   alu_control_e, alu_src_e, alu_a_pc_e, jalr_e, pc_src_e : EX controls
//   mem_write_m, reg_write_m : MEM controls
//   reg_write_w, result_src_w: WB controls
module pipelined_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter bit EN_JUMP    = 1'b1,
  parameter bit EN_UPPER   = 1'b1,
  parameter bit EN_BR_EXT  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  hold,
  input  logic                  flush_e,
  input  logic                  zero_e,
  input  logic                  lt_e,
  input  logic                  ltu_e,
  output logic [2:0]            imm_src_d,
  output logic                  illegal_d,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic                  alu_src_e,
  output logic                  alu_a_pc_e,
  output logic                  jalr_e,
  output logic                  pc_src_e,
  output logic                  mem_write_m,
  output logic                  reg_write_m,
  output logic                  reg_write_w,
  output logic [1:0]            result_src_w
);

  e_ctrl_t ctrl_d;
  logic    illegal;

  e_ctrl_t ctrl_e_p0;
  m_ctrl_t ctrl_m_p1;
  w_ctrl_t ctrl_w_p2;
  logic    vld_p0;
  logic    vld_p1;
  logic    vld_p2;

  ctrl_decoder #(
    .EN_JUMP   (EN_JUMP),
    .EN_UPPER  (EN_UPPER),
    .EN_BR_EXT (EN_BR_EXT)
  ) u_dec (
    .op      (op),
    .funct3  (funct3),
    .funct7  (funct7),
    .ctrl    (ctrl_d),
    .imm_src (imm_src_d),
    .illegal (illegal)
  );

  assign illegal_d = illegal;

  function automatic logic branch_cond(input logic [2:0] f3,
                                       input logic       zero,
                                       input logic       lt,
                                       input logic       ltu);
    logic r;
    case (f3)
      3'b000:  r = zero;
      3'b001:  r = !zero;
      3'b100:  r = lt;
      3'b101:  r = !lt;
      3'b110:  r = ltu;
      3'b111:  r = !ltu;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // hold outranks flush_e: the hazard unit keeps flush asserted until the
  // memory wait ends, so the bubble still lands on the first free edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_e_p0 <= E_BUBBLE;
      ctrl_m_p1 <= '0;
      ctrl_w_p2 <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
    end else if (!hold) begin
      // D -> E
      if (flush_e || illegal) begin
        ctrl_e_p0 <= E_BUBBLE;
        vld_p0    <= 1'b0;
      end else begin
        ctrl_e_p0 <= ctrl_d;
        vld_p0    <= 1'b1;
      end
      // E -> M
      ctrl_m_p1 <= ctrl_e_p0.m;
      vld_p1    <= vld_p0;
      // M -> W
      ctrl_w_p2 <= ctrl_m_p1.w;
      vld_p2    <= vld_p1;
    end
  end

  assign alu_control_e = ALU_CTRL_W'(ctrl_e_p0.alu_control);
  assign alu_src_e     = ctrl_e_p0.alu_src;
  assign alu_a_pc_e    = ctrl_e_p0.alu_a_pc;
  assign jalr_e        = ctrl_e_p0.jalr;
  assign pc_src_e      = vld_p0 &&
                         (ctrl_e_p0.jump ||
                          (ctrl_e_p0.branch &&
                           branch_cond(ctrl_e_p0.funct3, zero_e, lt_e, ltu_e)));

  assign mem_write_m   = vld_p1 && ctrl_m_p1.mem_write;
  assign reg_write_m   = vld_p1 && ctrl_m_p1.w.reg_write;

  assign reg_write_w   = vld_p2 && ctrl_w_p2.reg_write;
  assign result_src_w  = ctrl_w_p2.result_src;

endmodule
